apb_rr_arbiter: RTL and testbench

APB_RR_ARBITER -- requirements
Module: apb_rr_arbiter

---
 rtl/apb_rr_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_rr_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - two-requester round-robin arbiter driving one APB requester port (optional timeout: APB_ARB_TIMEOUT_EN)
module apb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [1:0]              req_valid,
    input  logic [1:0]              req_write,
    input  logic [2*ADDR_WIDTH-1:0] req_addr,
    input  logic [2*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]              req_ready,
    output logic [1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_slverr,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_grant;   // requester granted most recently; reset to 1 so requester 0 wins first
    logic owner;        // requester that owns the transfer in flight
    logic winner;
    logic accept;
    logic done;
    logic timeout;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign timeout = (state == ACCESS) && !PREADY
                     && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Count ACCESS cycles spent waiting for PREADY; cleared outside ACCESS
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!PREADY) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Round-robin pick: a lone requester always wins, on contention the one not granted last wins
    always_comb begin
        winner = 1'b0;
        case (req_valid)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and APB control / accept strobes
    always_comb begin
        state_nxt = state;
        req_ready = 2'b00;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = winner ? 2'b10 : 2'b01;
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY || timeout) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the accepted request and register the completion response
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_valid  <= 2'b00;
            rsp_rdata  <= '0;
            rsp_slverr <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            if (accept) begin
                PADDR      <= winner ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
                PWDATA     <= winner ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
                PWRITE     <= req_write[winner];
                owner      <= winner;
                last_grant <= winner;
            end
            if (done) begin
                rsp_valid  <= owner ? 2'b10 : 2'b01;
                rsp_rdata  <= timeout ? '0 : PRDATA;
                rsp_slverr <= timeout | PSLVERR;
            end
        end
    end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// tb/tb_apb_rr_arbiter.sv - directed self-checking bench for apb_rr_arbiter
module tb_apb_rr_arbiter;

    localparam int AW = 12;
    localparam int DW = 32;

    logic          PCLK;
    logic          PRESETn;
    logic [1:0]    req_valid;
    logic [1:0]    req_write;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [1:0]    req_ready;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic [AW-1:0] PADDR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int checks;
    int errors;

    apb_rr_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .PADDR      (PADDR),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETn   = 1'b0;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        tick();
        tick();
        PRESETn = 1'b1;
        tick();
    endtask

    initial begin
        int  n;
        bit  seen;
        checks = 0;
        errors = 0;

        do_reset();
        PRESETn = 1'b0;
        #1;
        check_eq("rst_psel",    PSEL,       0);
        check_eq("rst_penable", PENABLE,    0);
        check_eq("rst_rsp",     rsp_valid,  0);
        check_eq("rst_rdata",   rsp_rdata,  0);
        check_eq("rst_paddr",   PADDR,      0);
        check_eq("rst_ready",   req_ready,  0);
        tick();
        PRESETn = 1'b1;
        tick();

        // Requester 0 write, zero wait states
        req_valid = 2'b01;
        req_write = 2'b01;
        req_addr  = {12'h000, 12'h100};
        req_wdata = {32'h0, 32'hA5A5_A5A5};
        PREADY    = 1'b1;
        PRDATA    = 32'h1234_5678;
        #1;
        check_eq("wr_ready_n", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("wr_psel_n1",    PSEL,    1);
        check_eq("wr_penable_n1", PENABLE, 0);
        check_eq("wr_paddr",      PADDR,   12'h100);
        check_eq("wr_pwrite",     PWRITE,  1);
        check_eq("wr_pwdata",     PWDATA,  32'hA5A5_A5A5);
        check_eq("wr_ready_n1",   req_ready, 2'b00);
        tick();
        check_eq("wr_psel_n2",    PSEL,    1);
        check_eq("wr_penable_n2", PENABLE, 1);
        check_eq("wr_rsp_n2",     rsp_valid, 2'b00);
        tick();
        check_eq("wr_rsp_n3",     rsp_valid, 2'b01);
        check_eq("wr_slverr",     rsp_slverr, 0);
        check_eq("wr_rdata",      rsp_rdata, 32'h1234_5678);
        check_eq("wr_psel_n3",    PSEL,    0);

        // Requester 1 read with two wait states
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr  = {12'h100, 12'h000};
        PREADY    = 1'b0;
        PRDATA    = 32'hA5A5_A5A5;
        #1;
        check_eq("rd_ready", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        check_eq("rd_paddr",  PADDR,  12'h100);
        check_eq("rd_pwrite", PWRITE, 0);
        tick();
        check_eq("rd_acc1", PENABLE, 1);
        tick();
        check_eq("rd_acc2", PENABLE, 1);
        check_eq("rd_rsp_wait", rsp_valid, 2'b00);
        tick();
        check_eq("rd_acc3", PENABLE, 1);
        PREADY = 1'b1;
        tick();
        check_eq("rd_rsp",   rsp_valid, 2'b10);
        check_eq("rd_rdata", rsp_rdata, 32'hA5A5_A5A5);
        check_eq("rd_idle",  PSEL,      0);
        tick();
        check_eq("rd_rsp_pulse", rsp_valid, 2'b00);
        check_eq("rd_rdata_hold", rsp_rdata, 32'hA5A5_A5A5);

        // Continuous contention after reset: grants 0,1,0,1
        do_reset();
        req_valid = 2'b11;
        req_addr  = {12'h222, 12'h111};
        #1;
        check_eq("rr_grant0", req_ready, 2'b01);
        for (int i = 1; i < 4; i++) begin
            tick();
            tick();
            tick();
            check_eq("rr_grant", req_ready, (i % 2) ? 2'b10 : 2'b01);
            check_eq("rr_rsp",   rsp_valid, ((i - 1) % 2) ? 2'b10 : 2'b01);
        end
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        check_eq("rr_rsp_last", rsp_valid, 2'b10);

        // Slave error on read of 0xFFF
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr  = {12'h000, 12'hFFF};
        PSLVERR   = 1'b1;
        PREADY    = 1'b1;
        tick();
        req_valid = 2'b00;
        check_eq("err_paddr", PADDR, 12'hFFF);
        tick();
        tick();
        check_eq("err_rsp",    rsp_valid,  2'b01);
        check_eq("err_slverr", rsp_slverr, 1);
        PSLVERR = 1'b0;

        // Reset during ACCESS aborts the transfer
        req_valid = 2'b01;
        req_addr  = {12'h000, 12'h200};
        PREADY    = 1'b0;
        tick();
        req_valid = 2'b00;
        tick();
        check_eq("abort_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        #1;
        check_eq("abort_psel",    PSEL,      0);
        check_eq("abort_penable", PENABLE,   0);
        check_eq("abort_rsp",     rsp_valid, 0);
        PREADY = 1'b1;
        tick();
        tick();
        PRESETn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid != 2'b00) seen = 1'b1;
        end
        check_eq("abort_no_rsp", seen, 0);
        req_valid = 2'b11;
        #1;
        check_eq("abort_grant0", req_ready, 2'b01);
        req_valid = 2'b00;
        #1;

        // Completer never ready
        req_valid = 2'b10;
        req_write = 2'b00;
        req_addr  = {12'h300, 12'h000};
        PREADY    = 1'b0;
        PRDATA    = 32'hDEAD_BEEF;
        tick();
        req_valid = 2'b00;
        tick();
`ifdef APB_ARB_TIMEOUT_EN
        n = 0;
        while (rsp_valid == 2'b00 && n < 50) begin
            if (PENABLE) n++;
            tick();
        end
        check_eq("to_access_cycles", n, 16);
        check_eq("to_rsp",    rsp_valid,  2'b10);
        check_eq("to_slverr", rsp_slverr, 1);
        check_eq("to_rdata",  rsp_rdata,  0);
        check_eq("to_idle",   PSEL,       0);
`else
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid != 2'b00) seen = 1'b1;
            tick();
        end
        check_eq("hang_psel",    PSEL,    1);
        check_eq("hang_penable", PENABLE, 1);
        check_eq("hang_no_rsp",  seen,    0);
`endif
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
